// File: rtl/cache_l1_ctrl.sv
// cache_l1_ctrl: sequences one CPU access at a time through a 2-way
// write-through L1 and the L2 behind it.
// Read misses are refilled from L2. Every write goes to L2, and a write that
// hits in L1 also updates L1. Saturating hit/miss counters are kept.
module cache_l1_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int L2_TIMEOUT = 15,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  // CPU side
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              cpu_err,
  // L1 side
  output logic [ADDR_W-1:0] l1_addr,
  output logic              l1_wren,
  output logic [DATA_W-1:0] l1_data,
  output logic              l1_fill,
  input  logic              l1_hit,
  input  logic [DATA_W-1:0] l1_q,
  // L2 side
  output logic              l2_req,
  output logic              l2_wren,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_rdata,
  // statistics
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  // The timeout counter only has to count up to L2_TIMEOUT-1.
  localparam int TO_W = (L2_TIMEOUT < 2) ? 1 : $clog2(L2_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(L2_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_L1_WR,
    S_L2_ACC,
    S_FILL,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                hit_q, hit_d;
  logic                err_q, err_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                hit_inc, miss_inc;

  // State, latched request and statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wren_q     <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wren_q     <= wren_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state logic: request latching, hit/miss decision, L2 wait and timeout.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wren_d   = wren_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    err_d    = err_q;
    tcnt_d   = tcnt_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wren_d  = cpu_wren;
          wdata_d = cpu_wdata;
          rdata_d = '0;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_CHECK;
      S_CHECK: begin
        if (l1_hit) begin
          hit_d   = 1'b1;
          hit_inc = 1'b1;
          if (wren_q) begin
            state_d = S_L1_WR;
          end else begin
            rdata_d = l1_q;
            state_d = S_RESP;
          end
        end else begin
          miss_inc = 1'b1;
          tcnt_d   = '0;
          state_d  = S_L2_ACC;
        end
      end
      S_L1_WR: begin
        tcnt_d  = '0;
        state_d = S_L2_ACC;
      end
      S_L2_ACC: begin
        if (l2_ack) begin
          if (wren_q) begin
            state_d = S_RESP;
          end else begin
            rdata_d = l2_rdata;
            state_d = S_FILL;
          end
        end else if (tcnt_q == TO_LAST) begin
          // L2 never answered: report an error and skip the refill.
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_FILL: state_d = S_RESP;
      S_RESP: begin
        hit_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating statistics; a clear takes priority over a same-cycle increment.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (stats_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1)) begin
        hit_cnt_d = hit_cnt_q + 1'b1;
      end
      if (miss_inc && (miss_cnt_q != '1)) begin
        miss_cnt_d = miss_cnt_q + 1'b1;
      end
    end
  end

  // Output decode: every strobe and bus is zero outside the states that own it.
  always_comb begin
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    cpu_rdata = '0;
    cpu_hit   = 1'b0;
    cpu_err   = 1'b0;
    l1_addr   = '0;
    l1_wren   = 1'b0;
    l1_data   = '0;
    l1_fill   = 1'b0;
    l2_req    = 1'b0;
    l2_wren   = 1'b0;
    l2_addr   = '0;
    l2_wdata  = '0;
    unique case (state_q)
      S_IDLE:   cpu_ready = 1'b1;
      S_LOOKUP: l1_addr   = addr_q;
      S_L1_WR: begin
        l1_addr = addr_q;
        l1_wren = 1'b1;
        l1_data = wdata_q;
      end
      S_L2_ACC: begin
        l2_req   = 1'b1;
        l2_wren  = wren_q;
        l2_addr  = addr_q;
        l2_wdata = wdata_q;
      end
      S_FILL: begin
        l1_addr = addr_q;
        l1_wren = 1'b1;
        l1_fill = 1'b1;
        l1_data = rdata_q;
      end
      S_RESP: begin
        cpu_done  = 1'b1;
        cpu_rdata = wren_q ? '0 : rdata_q;
        cpu_hit   = hit_q;
        cpu_err   = err_q;
      end
      default: ;
    endcase
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_l1_ctrl.sv
// tb_cache_l1_ctrl: scoreboard bench for cache_l1_ctrl with simple L1/L2 models.
// Expected responses are queued when a request is issued; responses seen on
// cpu_done are queued by a monitor, and each scenario task compares the pairs.
module tb_cache_l1_ctrl;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 16;
  localparam int L2_TIMEOUT = 15;
  // Narrow counters so that saturation at all-ones is reachable quickly.
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cpu_req = 1'b0;
  logic              cpu_wren = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ready, cpu_done, cpu_hit, cpu_err;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] l1_addr;
  logic              l1_wren, l1_fill;
  logic [DATA_W-1:0] l1_data;
  logic              l1_hit = 1'b0;
  logic [DATA_W-1:0] l1_q = '0;
  logic              l2_req, l2_wren;
  logic [ADDR_W-1:0] l2_addr;
  logic [DATA_W-1:0] l2_wdata;
  logic              l2_ack = 1'b0;
  logic [DATA_W-1:0] l2_rdata = '0;
  logic              stats_clr = 1'b0;
  logic [CNT_W-1:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  cache_l1_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .L2_TIMEOUT(L2_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .cpu_err(cpu_err),
    .l1_addr(l1_addr), .l1_wren(l1_wren), .l1_data(l1_data), .l1_fill(l1_fill),
    .l1_hit(l1_hit), .l1_q(l1_q),
    .l2_req(l2_req), .l2_wren(l2_wren), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_ack(l2_ack), .l2_rdata(l2_rdata),
    .stats_clr(stats_clr), .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              hit;
    logic              err;
    int                lat;   // expected: latency edge; observed: edge number of cpu_done
  } resp_t;

  resp_t exp_q[$];
  resp_t obs_q[$];

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  int accept_edge = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Monitor totals.
  int n_l1_wr = 0, n_fill = 0, n_l2_req = 0, n_done = 0;
  logic [DATA_W-1:0] last_l1_data = '0, last_fill_data = '0, last_l2_wdata = '0;
  logic [ADDR_W-1:0] last_fill_addr = '0, last_l2_addr = '0;
  logic              last_fill_wren = 1'b0, last_l2_wren = 1'b0;

  // L2 responder configuration: ack after cfg_ack_delay cycles of l2_req (-1 = never).
  int                cfg_ack_delay = -1;
  logic [DATA_W-1:0] cfg_l2_data = '0;
  int                l2_cyc = 0;

  always @(posedge clk) edge_cnt++;

  always @(posedge clk) begin
    #1;
    if (l2_req) begin
      l2_ack   = (l2_cyc == cfg_ack_delay);
      l2_rdata = (l2_cyc == cfg_ack_delay) ? cfg_l2_data : '0;
      l2_cyc++;
    end else begin
      l2_ack   = 1'b0;
      l2_rdata = '0;
      l2_cyc   = 0;
    end
  end

  always @(negedge clk) begin
    if (l1_wren && !l1_fill) begin
      n_l1_wr++;
      last_l1_data = l1_data;
    end
    if (l1_fill) begin
      n_fill++;
      last_fill_data = l1_data;
      last_fill_addr = l1_addr;
      last_fill_wren = l1_wren;
    end
    if (l2_req) begin
      n_l2_req++;
      last_l2_wren  = l2_wren;
      last_l2_wdata = l2_wdata;
      last_l2_addr  = l2_addr;
    end
    if (cpu_done) begin
      n_done++;
      obs_q.push_back('{cpu_rdata, cpu_hit, cpu_err, edge_cnt});
    end
  end

  // Present one request for one cycle; records the accept edge number.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    cpu_req   = 1'b1;
    cpu_wren  = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    @(posedge clk); #1;
    accept_edge = edge_cnt;
    cpu_req   = 1'b0;
    cpu_wren  = 1'b0;
    cpu_wdata = '0;
  endtask

  // Wait (bounded) for the next observed response and pair it with the expected one.
  task automatic wait_done(output bit got, output resp_t o, output resp_t e);
    got = 1'b0;
    o = '{'0, 1'b0, 1'b0, 0};
    e = '{'0, 1'b0, 1'b0, 0};
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk); #1;
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        got = 1'b1;
      end
    end
    if (got)
      $display("txn addr=%h rdata=%h hit=%0d err=%0d edge=%0d",
               cpu_addr, o.rdata, o.hit, o.err, o.lat - accept_edge + 1);
  endtask

  task automatic test_reset();
    int wr0, fl0, rq0, dn0;
    bit seen;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || cpu_done !== 1'b0 || l2_req !== 1'b0 || l1_wren !== 1'b0 ||
        hit_count !== '0 || miss_count !== '0) begin
      failures++;
      $display("FAIL reset_state: ready=%b done=%b l2_req=%b l1_wren=%b hits=%0d misses=%0d, required 1 0 0 0 0 0",
               cpu_ready, cpu_done, l2_req, l1_wren, hit_count, miss_count);
    end
    reset = 1'b1;
    // Start a read miss that L2 never answers, then reset in the middle of it.
    l1_hit = 1'b0;
    cfg_ack_delay = -1;
    issue(1'b0, 7'h33, '0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (l2_req === 1'b1);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_l2_req_reached: l2_req never seen, required 1");
    end
    reset = 1'b0;
    #1;
    wr0 = n_l1_wr; fl0 = n_fill; rq0 = n_l2_req; dn0 = n_done;
    checks++;
    if (l2_req !== 1'b0 || cpu_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_async: l2_req=%b ready=%b, required 0 1", l2_req, cpu_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (cpu_ready !== 1'b1 || l2_req !== 1'b0 || hit_count !== CNT_W'(exp_hits) ||
        miss_count !== CNT_W'(exp_misses)) begin
      failures++;
      $display("FAIL reset_release: ready=%b l2_req=%b hits=%0d misses=%0d, required 1 0 0 0",
               cpu_ready, l2_req, hit_count, miss_count);
    end
    checks++;
    if (n_done != dn0 || n_l1_wr != wr0 || n_fill != fl0 || n_l2_req != rq0) begin
      failures++;
      $display("FAIL reset_abandon: done=%0d l1_wr=%0d fill=%0d l2_req=%0d new events, required all 0",
               n_done - dn0, n_l1_wr - wr0, n_fill - fl0, n_l2_req - rq0);
    end
    obs_q.delete();
  endtask

  task automatic test_read_hit();
    bit got;
    resp_t o, e;
    int rq0;
    l1_hit = 1'b1;
    l1_q   = 16'h0ABC;
    rq0 = n_l2_req;
    issue(1'b0, 7'h12, '0);
    exp_q.push_back('{16'h0ABC, 1'b1, 1'b0, 3});
    if (exp_hits < CNT_MAX) exp_hits++;
    wait_done(got, o, e);
    checks++;
    if (!got || o.rdata !== e.rdata || o.hit !== e.hit || o.err !== e.err ||
        (o.lat - accept_edge + 1) != e.lat) begin
      failures++;
      $display("FAIL read_hit_resp: got=%0d rdata=%h hit=%b err=%b edge=%0d, required %h %b %b %0d",
               got, o.rdata, o.hit, o.err, o.lat - accept_edge + 1, e.rdata, e.hit, e.err, e.lat);
    end
    checks++;
    if (hit_count !== CNT_W'(exp_hits) || n_l2_req != rq0) begin
      failures++;
      $display("FAIL read_hit_stats: hits=%0d l2_req_cycles=%0d, required %0d 0",
               hit_count, n_l2_req - rq0, exp_hits);
    end
  endtask

  task automatic test_read_miss();
    bit got;
    resp_t o, e;
    int rq0, fl0, wr0;
    l1_hit = 1'b0;
    l1_q   = 16'h5555;
    cfg_ack_delay = 2;
    cfg_l2_data   = 16'h1234;
    rq0 = n_l2_req; fl0 = n_fill; wr0 = n_l1_wr;
    issue(1'b0, 7'h45, '0);
    exp_q.push_back('{16'h1234, 1'b0, 1'b0, 7});
    if (exp_misses < CNT_MAX) exp_misses++;
    wait_done(got, o, e);
    checks++;
    if (!got || o.rdata !== e.rdata || o.hit !== e.hit || o.err !== e.err ||
        (o.lat - accept_edge + 1) != e.lat) begin
      failures++;
      $display("FAIL read_miss_resp: got=%0d rdata=%h hit=%b err=%b edge=%0d, required %h %b %b %0d",
               got, o.rdata, o.hit, o.err, o.lat - accept_edge + 1, e.rdata, e.hit, e.err, e.lat);
    end
    checks++;
    if (n_fill - fl0 != 1 || last_fill_data !== 16'h1234 || last_fill_addr !== 7'h45 ||
        last_fill_wren !== 1'b1 || n_l1_wr != wr0) begin
      failures++;
      $display("FAIL read_miss_fill: fills=%0d data=%h addr=%h wren=%b l1_writes=%0d, required 1 1234 45 1 0",
               n_fill - fl0, last_fill_data, last_fill_addr, last_fill_wren, n_l1_wr - wr0);
    end
    checks++;
    if (n_l2_req - rq0 != 3 || last_l2_addr !== 7'h45 || last_l2_wren !== 1'b0 ||
        miss_count !== CNT_W'(exp_misses)) begin
      failures++;
      $display("FAIL read_miss_l2: req_cycles=%0d addr=%h wren=%b misses=%0d, required 3 45 0 %0d",
               n_l2_req - rq0, last_l2_addr, last_l2_wren, miss_count, exp_misses);
    end
  endtask

  task automatic test_write_hit();
    bit got;
    resp_t o, e;
    int rq0, fl0, wr0;
    l1_hit = 1'b1;
    l1_q   = 16'hAAAA;
    cfg_ack_delay = 0;
    rq0 = n_l2_req; fl0 = n_fill; wr0 = n_l1_wr;
    issue(1'b1, 7'h08, 16'h00FF);
    exp_q.push_back('{16'h0000, 1'b1, 1'b0, 5});
    if (exp_hits < CNT_MAX) exp_hits++;
    wait_done(got, o, e);
    checks++;
    if (!got || o.rdata !== e.rdata || o.hit !== e.hit || o.err !== e.err ||
        (o.lat - accept_edge + 1) != e.lat) begin
      failures++;
      $display("FAIL write_hit_resp: got=%0d rdata=%h hit=%b err=%b edge=%0d, required %h %b %b %0d",
               got, o.rdata, o.hit, o.err, o.lat - accept_edge + 1, e.rdata, e.hit, e.err, e.lat);
    end
    checks++;
    if (n_l1_wr - wr0 != 1 || last_l1_data !== 16'h00FF || n_fill != fl0) begin
      failures++;
      $display("FAIL write_hit_l1: writes=%0d data=%h fills=%0d, required 1 00ff 0",
               n_l1_wr - wr0, last_l1_data, n_fill - fl0);
    end
    checks++;
    if (n_l2_req - rq0 != 1 || last_l2_wren !== 1'b1 || last_l2_wdata !== 16'h00FF ||
        hit_count !== CNT_W'(exp_hits)) begin
      failures++;
      $display("FAIL write_hit_l2: req_cycles=%0d wren=%b wdata=%h hits=%0d, required 1 1 00ff %0d",
               n_l2_req - rq0, last_l2_wren, last_l2_wdata, hit_count, exp_hits);
    end
  endtask

  task automatic test_miss_timeout();
    bit got;
    resp_t o, e;
    int rq0, fl0, wr0;
    // Write miss, acked in the first L2 cycle.
    l1_hit = 1'b0;
    cfg_ack_delay = 0;
    fl0 = n_fill; wr0 = n_l1_wr;
    issue(1'b1, 7'h21, 16'hBEEF);
    exp_q.push_back('{16'h0000, 1'b0, 1'b0, 4});
    if (exp_misses < CNT_MAX) exp_misses++;
    wait_done(got, o, e);
    checks++;
    if (!got || o.rdata !== e.rdata || o.hit !== e.hit || o.err !== e.err ||
        (o.lat - accept_edge + 1) != e.lat) begin
      failures++;
      $display("FAIL write_miss_resp: got=%0d rdata=%h hit=%b err=%b edge=%0d, required %h %b %b %0d",
               got, o.rdata, o.hit, o.err, o.lat - accept_edge + 1, e.rdata, e.hit, e.err, e.lat);
    end
    checks++;
    if (n_l1_wr != wr0 || n_fill != fl0 || last_l2_wdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_miss_l1: l1_writes=%0d fills=%0d l2_wdata=%h, required 0 0 beef",
               n_l1_wr - wr0, n_fill - fl0, last_l2_wdata);
    end
    // Read miss that L2 never acknowledges.
    cfg_ack_delay = -1;
    rq0 = n_l2_req; fl0 = n_fill;
    issue(1'b0, 7'h50, '0);
    exp_q.push_back('{16'h0000, 1'b0, 1'b1, 3 + L2_TIMEOUT});
    if (exp_misses < CNT_MAX) exp_misses++;
    wait_done(got, o, e);
    checks++;
    if (!got || o.rdata !== e.rdata || o.hit !== e.hit || o.err !== e.err ||
        (o.lat - accept_edge + 1) != e.lat) begin
      failures++;
      $display("FAIL timeout_resp: got=%0d rdata=%h hit=%b err=%b edge=%0d, required %h %b %b %0d",
               got, o.rdata, o.hit, o.err, o.lat - accept_edge + 1, e.rdata, e.hit, e.err, e.lat);
    end
    checks++;
    if (n_l2_req - rq0 != L2_TIMEOUT || n_fill != fl0 || miss_count !== CNT_W'(exp_misses)) begin
      failures++;
      $display("FAIL timeout_l2: req_cycles=%0d fills=%0d misses=%0d, required %0d 0 %0d",
               n_l2_req - rq0, n_fill - fl0, miss_count, L2_TIMEOUT, exp_misses);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    resp_t o, e;
    logic [DATA_W-1:0] d;
    l1_hit = 1'b1;
    // More hits than the counter can hold, issued as soon as the controller is idle.
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      d = DATA_W'($urandom_range(0, 16'hFFFF));
      l1_q = d;
      issue(1'b0, ADDR_W'(i * 5), '0);
      exp_q.push_back('{d, 1'b1, 1'b0, 3});
      if (exp_hits < CNT_MAX) exp_hits++;
      wait_done(got, o, e);
      checks++;
      if (!got || o.rdata !== e.rdata || o.hit !== e.hit || o.err !== e.err ||
          (o.lat - accept_edge + 1) != e.lat) begin
        failures++;
        $display("FAIL b2b_resp[%0d]: got=%0d rdata=%h hit=%b err=%b edge=%0d, required %h %b %b %0d",
                 i, got, o.rdata, o.hit, o.err, o.lat - accept_edge + 1, e.rdata, e.hit, e.err, e.lat);
      end
    end
    checks++;
    if (hit_count !== CNT_W'(CNT_MAX)) begin
      failures++;
      $display("FAIL hit_saturate: hits=%0d, required %0d", hit_count, CNT_MAX);
    end
  endtask

  task automatic test_stats_clr();
    bit got;
    resp_t o, e;
    l1_hit = 1'b0;
    cfg_ack_delay = 0;
    cfg_l2_data   = 16'h7777;
    issue(1'b0, 7'h3C, '0);
    exp_q.push_back('{16'h7777, 1'b0, 1'b0, 5});
    // The miss increment lands on the edge that ends CHECK; clear on that same edge.
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    checks++;
    if (miss_count !== CNT_W'(exp_misses) || hit_count !== CNT_W'(exp_hits)) begin
      failures++;
      $display("FAIL stats_clr_wins: misses=%0d hits=%0d, required 0 0", miss_count, hit_count);
    end
    wait_done(got, o, e);
    checks++;
    if (!got || o.rdata !== e.rdata || o.hit !== e.hit || o.err !== e.err ||
        (o.lat - accept_edge + 1) != e.lat) begin
      failures++;
      $display("FAIL clr_miss_resp: got=%0d rdata=%h hit=%b err=%b edge=%0d, required %h %b %b %0d",
               got, o.rdata, o.hit, o.err, o.lat - accept_edge + 1, e.rdata, e.hit, e.err, e.lat);
    end
    // Counting resumes from zero after the clear.
    l1_hit = 1'b1;
    l1_q   = 16'h4321;
    issue(1'b0, 7'h3C, '0);
    exp_q.push_back('{16'h4321, 1'b1, 1'b0, 3});
    exp_hits++;
    wait_done(got, o, e);
    checks++;
    if (!got || o.rdata !== e.rdata || hit_count !== CNT_W'(exp_hits) ||
        miss_count !== CNT_W'(exp_misses)) begin
      failures++;
      $display("FAIL after_clr: got=%0d rdata=%h hits=%0d misses=%0d, required %h %0d %0d",
               got, o.rdata, hit_count, miss_count, e.rdata, exp_hits, exp_misses);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write_hit();
    test_miss_timeout();
    test_back_to_back();
    test_stats_clr();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
